// File: rtl/alu_pkg.sv
// Shared opcode encodings and default datapath width for the ALU slice.
package alu_pkg;
  localparam int WIDTH_DEFAULT = 8;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_XOR  = 2'b11;
endpackage

// File: rtl/alu_addsub.sv
// Combinational adder/subtractor. Subtraction is done as a + ~b + ~cin, so the
// carry out of that sum is the inverse of the borrow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout_or_borrow,
  output logic             ovf
);
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [WIDTH:0]   total;

  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
  assign total   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};

  assign sum            = total[WIDTH-1:0];
  assign cout_or_borrow = sub ? ~total[WIDTH] : total[WIDTH];
  // Signed overflow in addition terms; only meaningful when sub is low.
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu_module.sv
// Four-operation ALU with registered result Y and status flag ST; one new
// operation is accepted on every rising clock edge.
module alu_module
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CY,
  input  logic [1:0]       OP,
  output logic [WIDTH-1:0] Y,
  output logic             ST
);
  logic [WIDTH-1:0] as_sum;
  logic             as_cout_or_borrow;
  logic             as_ovf;
  logic [WIDTH-1:0] y_next;
  logic             st_next;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a              (A),
    .b              (B),
    .cin            (CY),
    .sub            (OP == OP_SUB),
    .sum            (as_sum),
    .cout_or_borrow (as_cout_or_borrow),
    .ovf            (as_ovf)
  );

  always_comb begin
    y_next  = A;
    st_next = 1'b0;
    case (OP)
      OP_PASS: begin
        y_next  = A;
        st_next = 1'b0;
      end
      OP_ADD: begin
        y_next  = as_sum;
        st_next = as_ovf;
      end
      OP_SUB: begin
        y_next  = as_sum;
        st_next = as_cout_or_borrow;
      end
      OP_XOR: begin
        y_next  = A ^ B;
        st_next = 1'b0;
      end
      default: begin
        y_next  = A;
        st_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Y  <= '0;
      ST <= 1'b0;
    end else begin
      Y  <= y_next;
      ST <= st_next;
    end
  end
endmodule

// File: tb/tb_alu_module.sv
// Scoreboard bench for alu_module: stimulus pushes hand-computed results, a
// monitor pops and compares them one edge after each operation is issued.
module tb_alu_module;
  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic       CY;
  logic [1:0] OP;
  logic [7:0] Y;
  logic       ST;

  typedef struct {
    logic [7:0] y;
    logic       st;
    int         idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;
  int   n_issued;

  alu_module #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .CY  (CY),
    .OP  (OP),
    .Y   (Y),
    .ST  (ST)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, req);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  // Drive one operation between edges and record its expected result.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic cy,
                       input logic [1:0] op, input logic [7:0] y, input logic st);
    exp_t e;
    @(negedge clk);
    A  = a;
    B  = b;
    CY = cy;
    OP = op;
    e.y   = y;
    e.st  = st;
    e.idx = n_issued;
    exp_q.push_back(e);
    $display("issue #%0d: OP=%b A=0x%02h B=0x%02h CY=%b -> Y=0x%02h ST=%b",
             n_issued, op, a, b, cy, y, st);
    n_issued++;
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check8($sformatf("op%0d_Y", e.idx), Y, e.y);
      check1($sformatf("op%0d_ST", e.idx), ST, e.st);
      $display("result #%0d: Y=0x%02h ST=%b", e.idx, Y, ST);
    end
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    n_issued = 0;
    rst = 1'b1;
    A   = 8'hAA;
    B   = 8'h00;
    CY  = 1'b0;
    OP  = 2'b01;
    #1;
    check8("reset_imm_Y", Y, 8'h00);
    check1("reset_imm_ST", ST, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check8($sformatf("reset_edge%0d_Y", i), Y, 8'h00);
      check1($sformatf("reset_edge%0d_ST", i), ST, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;

    issue(8'hAA, 8'h0F, 1'b0, 2'b00, 8'hAA, 1'b0);
    issue(8'h7F, 8'h01, 1'b1, 2'b01, 8'h81, 1'b1);
    issue(8'hFF, 8'h01, 1'b0, 2'b01, 8'h00, 1'b0);
    issue(8'hAA, 8'h55, 1'b0, 2'b10, 8'h55, 1'b0);
    issue(8'h00, 8'h00, 1'b1, 2'b10, 8'hFF, 1'b1);
    issue(8'hAA, 8'hAA, 1'b0, 2'b11, 8'h00, 1'b0);
    issue(8'hAA, 8'h0F, 1'b0, 2'b11, 8'hA5, 1'b0);
    issue(8'h3C, 8'hFF, 1'b1, 2'b00, 8'h3C, 1'b0);
    issue(8'hFF, 8'h00, 1'b1, 2'b01, 8'h00, 1'b0);
    issue(8'h10, 8'h20, 1'b0, 2'b10, 8'hF0, 1'b1);
    issue(8'h0F, 8'hF0, 1'b1, 2'b11, 8'hFF, 1'b0);
    issue(8'h80, 8'h80, 1'b0, 2'b01, 8'h00, 1'b1);
    issue(8'h80, 8'h01, 1'b0, 2'b10, 8'h7F, 1'b0);
    issue(8'h7F, 8'h01, 1'b1, 2'b01, 8'h81, 1'b1);
    drain();

    // Mid-cycle reset with a nonzero result held: outputs clear before any edge.
    @(posedge clk);
    #3;
    check8("pre_reset_Y", Y, 8'h81);
    check1("pre_reset_ST", ST, 1'b1);
    rst = 1'b1;
    #1;
    check8("async_reset_Y", Y, 8'h00);
    check1("async_reset_ST", ST, 1'b0);
    @(posedge clk);
    #1;
    check8("async_hold_Y", Y, 8'h00);
    check1("async_hold_ST", ST, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    issue(8'hAA, 8'h0F, 1'b1, 2'b11, 8'hA5, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_module.md
Name: alu_module

Overview:
- 8-bit, four-operation ALU with a carry/borrow input, an 8-bit result Y and a single status flag ST.
- Operands and opcode are sampled every clock; Y and ST are registered outputs.
- Used as the arithmetic datapath element of the small processor/datapath exercises. No handshake: a new operation is accepted every cycle.

Parameters:
- WIDTH, 8, operand/result width in bits. Only 8 is verified.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- CY  input  1  carry-in for ADD, borrow-in for SUB; ignored otherwise
- OP  input  2  operation select
- Y  output  WIDTH  registered result
- ST  output  1  registered status flag

Behaviour:
- Reset:
  - rst high asynchronously forces Y=0 and ST=0, independent of clk.
  - Outputs hold 0 while rst is high.
  - The first sample is taken on the first rising clk edge after rst deasserts.
- Latency and throughput:
  - Operands and OP are sampled on each rising clk edge.
  - Y/ST reflect that sample after the edge (1-cycle latency).
  - Throughput is one operation per cycle; outputs hold between edges.
- OP=00 PASS:
  - Y=A, ST=0.
- OP=01 ADD:
  - Y = (A + B + CY) mod 2^WIDTH.
  - ST = two's-complement signed overflow: set iff A[7]==B[7] and Y[7]!=A[7].
  - Unsigned carry-out is not reported.
- OP=10 SUB:
  - Y = (A - B - CY) mod 2^WIDTH.
  - ST = unsigned borrow-out: set iff A < B + CY, evaluated at WIDTH+1 bits.
  - Signed overflow is not reported for SUB.
- OP=11 XOR:
  - Y = A XOR B, ST=0.
- Arithmetic width rules:
  - Internal sum/difference uses WIDTH+1 bits.
  - Y takes the low WIDTH bits.
  - No saturation; wrap-around is modular.
- Boundary conditions:
  - ADD 0xFF+0x00+1 gives Y=0x00, ST=0 (no signed overflow: -1+0+1=0).
  - SUB 0x00-0x00-1 gives Y=0xFF, ST=1.
  - CY is ignored for PASS and XOR.
  - Any OP change takes effect on the next edge; there is no pipeline hazard state.
  - Reset asserted mid-stream discards the in-flight result immediately.
- X/Z handling:
  - Inputs are assumed driven. No X-propagation guarantees are given beyond simulator semantics.

Decomposition:
- Shared package alu_pkg:
  - localparams OP_PASS=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_XOR=2'b11
  - the WIDTH default
- Sub-module alu_addsub:
  - purely combinational WIDTH-bit adder/subtractor
  - inputs: a, b, cin, sub
  - outputs: sum, cout_or_borrow, ovf
  - SUB is implemented as A + ~B + ~CY with borrow = ~carry-out.
- Top level holds the opcode mux and the output register.

Test Plan:
- Reset: assert rst with A=0xAA, OP=01 and clocks running -> Y=0x00, ST=0 immediately and on every edge while rst is high.
- PASS: A=0xAA, B=0x0F, CY=0, OP=00, one clk edge -> Y=0xAA, ST=0.
- ADD with signed overflow: A=0x7F, B=0x01, CY=1, OP=01 -> Y=0x81, ST=1. Also A=0xFF, B=0x01, CY=0 -> Y=0x00, ST=0.
- SUB without borrow: A=0xAA, B=0x55, CY=0, OP=10 -> Y=0x55, ST=0. With borrow: A=0x00, B=0x00, CY=1 -> Y=0xFF, ST=1.
- XOR: A=0xAA, B=0xAA, CY=0, OP=11 -> Y=0x00, ST=0. Also A=0xAA, B=0x0F -> Y=0xA5, ST=0.
- Back-to-back and async reset: change OP every cycle (00,01,10,11) and check each result appears exactly one edge later. Then assert rst between edges -> Y/ST clear before the next clk edge.
